md_seq: RTL and testbench
=========================

MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  EX-stage request to issue the operation in func; sampled only in IDLE.
REQ-004 SHALL have port: func  input  3  operation code: 0 NONE, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO; values 5-7 are treated as NONE.
REQ-005 SHALL have port: is_sign  input  1  1 = signed operands for MULT/DIV.
REQ-006 SHALL have port: a  input  32  forwarded rs operand.
REQ-007 SHALL have port: b  input  32  forwarded rt operand.
REQ-008 SHALL have port: abort  input  1  cancels any in-flight operation (EX flush or exception).
REQ-009 SHALL have port: busy  output  1  registered; 1 while an operation is in flight; consumed by stall detection.
REQ-010 SHALL have port: done  output  1  registered one-cycle pulse in the first cycle HI/LO hold a new MULT/DIV result.
REQ-011 SHALL have port: hi  output  32  architectural HI register.
REQ-012 SHALL have port: lo  output  32  architectural LO register.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-014 SHALL, in IDLE with start=1 and func=MTHI (MTLO), write a into hi (lo) at that edge, stay in IDLE and leave done low.
REQ-015 SHALL, in IDLE with start=1 and func=MULT or DIV, latch |a|, |b| (raw values when is_sign=0), the result-sign flags and the op, clear a 6-bit counter, and enter CALC.
REQ-016 SHALL, in CALC, perform one radix-2 step per cycle (shift-add for MULT, restoring for DIV) over 64-bit internal accumulators, and go to FIX after exactly 32 steps.
REQ-017 SHALL, in FIX, apply sign correction, update hi/lo, return to IDLE and assert done in the following cycle; start accepted at edge N gives hi/lo updated at edge N+33.
REQ-018 SHALL give MULT results hi:lo = full 64-bit product.
REQ-019 SHALL give DIV results lo = quotient truncated toward zero and hi = remainder carrying the sign of a.
REQ-020 SHALL, when b=0 on DIV, give lo=32'hFFFF_FFFF and hi=a with the normal latency and no exception.
REQ-021 SHALL, for signed DIV 0x8000_0000 / 0xFFFF_FFFF, give lo=0x8000_0000 and hi=0.
REQ-022 SHALL ignore start while busy=1; upstream stall logic holds the requester.
REQ-023 SHALL, on abort=1 in any state, return to IDLE at that edge, leave hi/lo unchanged, keep done low, and give abort priority over a simultaneous start.
REQ-024 SHALL treat start with func=NONE as a no-op.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=IDLE, busy=0, done=0, hi=0, lo=0 and the counter to 0, overriding start and abort.
REQ-026 SHALL allow rst during CALC/FIX to discard the operation without producing a done pulse.

Configuration
REQ-027 SHALL support macro MD_FAST_MUL_EN; when defined, MULT SHALL compute the product in one cycle into the FIX stage (IDLE->FIX), so hi/lo update at edge N+1 and done is asserted in the following cycle.
REQ-028 SHALL, without MD_FAST_MUL_EN, use the iterative 32-step MULT; DIV is always iterative.

Structure
REQ-029 SHALL place the func encodings (md_func_e), the state typedef and the constant MD_STEPS=32 in the shared package md_pkg.
REQ-030 SHALL place the radix-2 step datapath in one sub-module, md_step, with md_seq holding the state machine, counter, operand latches and hi/lo.

Verification
REQ-031 SHALL cover: signed MULT a=-3, b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; busy high for 33 cycles (1 with MD_FAST_MUL_EN); then one done pulse.
REQ-032 SHALL cover: signed DIV a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; unsigned DIV 100/7 -> lo=14, hi=2.
REQ-033 SHALL cover: DIV by zero a=0x1234 -> lo=0xFFFF_FFFF, hi=0x1234, done pulses normally.
REQ-034 SHALL cover: abort at cycle 10 of a DIV -> busy=0 next cycle, hi/lo keep prior values, no done pulse.
REQ-035 SHALL cover: MTHI a=0xDEAD_BEEF then MTLO a=5 on consecutive cycles -> hi=0xDEAD_BEEF, lo=5, busy stays 0.
REQ-036 SHALL cover: second start during CALC -> ignored, first result intact; rst mid-CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, state type and step count for the HI/LO multiply/divide sequencer
package md_pkg;

    typedef enum logic [2:0] {
        FUNC_NONE = 3'd0,
        FUNC_MULT = 3'd1,
        FUNC_DIV  = 3'd2,
        FUNC_MTHI = 3'd3,
        FUNC_MTLO = 3'd4
    } md_func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    localparam int MD_STEPS = 32;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one radix-2 step: shift-add multiply or restoring divide on a 64-bit accumulator
module md_step (
    input  logic        op_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    // MULT: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_sh   = {acc[63:32], acc[31]};
        diff     = rem_sh - {1'b0, opnd};
        acc_next = {sum, acc[31:1]};
        if (op_div) begin
            if (diff[32]) begin
                acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
            end else begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/md_seq.sv
// rtl/md_seq.sv - iterative MULT/DIV sequencer owning HI/LO; MD_FAST_MUL_EN selects single-cycle MULT
module md_seq
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func,
    input  logic        is_sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state, state_n;
    md_func_e    fcode;
    logic [5:0]  cnt;
    logic [63:0] acc, acc_step;
    logic [31:0] opnd, abs_a, abs_b;
    logic        op_div, neg_q, neg_r, b_zero;

    assign fcode = md_func_e'(func);
    assign abs_a = abs32(a, is_sign);
    assign abs_b = abs32(b, is_sign);
    assign busy  = (state != IDLE);

    md_step u_step (
        .op_div   (op_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && fcode == FUNC_DIV) begin
                        state_n = CALC;
                    end else if (start && fcode == FUNC_MULT) begin
`ifdef MD_FAST_MUL_EN
                        state_n = FIX;
`else
                        state_n = CALC;
`endif
                    end
                end
                CALC:    if (cnt == 6'(MD_STEPS - 1)) state_n = FIX;
                FIX:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (fcode)
                                FUNC_MTHI: hi <= a;
                                FUNC_MTLO: lo <= a;
                                FUNC_MULT, FUNC_DIV: begin
                                    cnt    <= '0;
                                    op_div <= (fcode == FUNC_DIV);
                                    neg_q  <= is_sign & (a[31] ^ b[31]);
                                    neg_r  <= is_sign & a[31];
                                    b_zero <= (b == 32'd0);
                                    if (fcode == FUNC_DIV) begin
                                        acc  <= {32'd0, abs_a};
                                        opnd <= abs_b;
                                    end else begin
`ifdef MD_FAST_MUL_EN
                                        acc  <= {32'd0, abs_a} * {32'd0, abs_b};
`else
                                        acc  <= {32'd0, abs_b};
`endif
                                        opnd <= abs_a;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        acc <= acc_step;
                        cnt <= cnt + 6'd1;
                    end
                    FIX: begin
                        done <= 1'b1;
                        if (op_div) begin
                            // remainder takes the dividend's sign; divide-by-zero forces an all-ones quotient
                            lo <= b_zero ? 32'hFFFF_FFFF : (neg_q ? 32'd0 - acc[31:0] : acc[31:0]);
                            hi <= neg_r ? 32'd0 - acc[63:32] : acc[63:32];
                        end else begin
                            {hi, lo} <= neg_q ? 64'd0 - acc : acc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// tb/tb_md_seq.sv - directed scoreboard bench for md_seq
module tb_md_seq;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, is_sign, abort;
    logic [2:0]  func;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

`ifdef MD_FAST_MUL_EN
    localparam int MULT_BUSY = 1;
`else
    localparam int MULT_BUSY = 33;
`endif

    md_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .func    (func),
        .is_sign (is_sign),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] av, input logic [31:0] bv);
        func    = f;
        is_sign = s;
        a       = av;
        b       = bv;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_busy);
        int          bcount;
        logic        seen;
        logic [63:0] expv;
        bcount = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcount++;
            step();
        end
        expv = exp_q.pop_front();
        check($sformatf("%s_done_seen", tag), 64'(seen), 64'd1);
        check($sformatf("%s_hilo", tag), {hi, lo}, expv);
        if (exp_busy >= 0) check($sformatf("%s_busy_cycles", tag), 64'(bcount), 64'(exp_busy));
        step();
        check($sformatf("%s_done_single", tag), 64'(done), 64'd0);
    endtask

    task automatic quiet_window(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            step();
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; func = 3'd3; is_sign = 1'b0; abort = 1'b1;
        a = 32'hFFFF_0000; b = 32'd0;
        step();
        step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        // MTHI then MTLO back to back
        func = 3'd3; a = 32'hDEAD_BEEF; start = 1'b1;
        step();
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        func = 3'd4; a = 32'd5;
        step();
        start = 1'b0;
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mthi_mtlo_hilo", {hi, lo}, 64'hDEAD_BEEF_0000_0005);

        // NONE and reserved encodings do nothing
        issue(3'd0, 1'b1, 32'h1, 32'h1);
        check("none_busy", 64'(busy), 64'd0);
        issue(3'd7, 1'b1, 32'h1, 32'h1);
        check("func7_busy", 64'(busy), 64'd0);
        check("noop_hilo", {hi, lo}, 64'hDEAD_BEEF_0000_0005);

        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        issue(3'd1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_result("mult_s", MULT_BUSY);

        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd2, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_s", 33);

        exp_q.push_back({32'd2, 32'd14});
        issue(3'd2, 1'b0, 32'd100, 32'd7);
        wait_result("div_u", 33);

        exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
        issue(3'd2, 1'b1, 32'h0000_1234, 32'd0);
        wait_result("div_zero", 33);

        exp_q.push_back({32'd0, 32'h8000_0000});
        issue(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 33);

        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        issue(3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_u", MULT_BUSY);

        // abort a DIV partway through, then abort racing a start
        issue(3'd2, 1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) step();
        check("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        step();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        start = 1'b1; func = 3'd3; a = 32'h1111_1111;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort_start_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check("abort_start_busy", 64'(busy), 64'd0);
        quiet_window("abort_no_done");

        // start while busy must be ignored
        exp_q.push_back({32'd2, 32'd14});
        issue(3'd2, 1'b0, 32'd100, 32'd7);
        start = 1'b1; func = 3'd3; a = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0;
        wait_result("restart_ignored", 30);

        // reset in the middle of a DIV
        issue(3'd2, 1'b0, 32'd500, 32'd9);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        quiet_window("rst_mid_no_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
